talon_dealer: RTL and testbench

Consumer end of the deal interface. The setup block streams the 24 undealt cards in as the face-down talon, and this block owns them for the rest of the game. It serves Klondike draw-3 requests by turning up to three talon cards face-up onto the waste, and exposes the top three waste cards to the move logic. It also removes the top waste card when the move logic plays it, and recycles the waste back into the talon when the talon is exhausted.

---
 rtl/talon_dealer.sv | 201 ++++++++++++++++++++
 tb/tb_talon_dealer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/talon_dealer.sv
// talon_dealer: owns the face-down talon and face-up waste for Klondike draw-3.
// Cards are streamed in by setup, turned onto the waste in groups of DRAW_N,
// removed from the waste top when played, and recycled when the talon runs out.
module talon_dealer #(
  parameter int DECK_MAX = 24,
  parameter int DRAW_N   = 3,
  parameter int CARD_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [CARD_W-1:0] load_card,
  output logic              load_ready,
  input  logic              setup_ready,
  input  logic              draw_req,
  input  logic              take_req,
  output logic              cmd_ready,
  output logic [CARD_W-1:0] waste0,
  output logic [CARD_W-1:0] waste1,
  output logic [CARD_W-1:0] waste2,
  output logic [2:0]        waste_valid,
  output logic [4:0]        talon_count,
  output logic [4:0]        waste_count,
  output logic [3:0]        pass_count,
  output logic              err
);

  localparam logic [4:0]        DECK_MAX_C = 5'(DECK_MAX);
  localparam logic [4:0]        DRAW_C     = 5'(DRAW_N);
  localparam logic [CARD_W-1:0] VIS_BIT    = {{(CARD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [4:0]        ptr_r, ptr_n;
  logic [4:0]        len_r, len_n;
  logic [4:0]        j_r, j_n;
  logic [3:0]        pass_r, pass_n;
  logic              err_n;
  logic              load_we_s;
  logic              shift_we_s;
  logic [4:0]        talon_s;
  logic [4:0]        step_s;
  logic [CARD_W-1:0] waste_n [3];
  logic [CARD_W-1:0] deck [0:DECK_MAX-1];

  assign talon_s = len_r - ptr_r;
  assign step_s  = (talon_s >= DRAW_C) ? DRAW_C : talon_s;

  // Next-state logic for the controller, pointer, length and sticky error.
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    len_n      = len_r;
    j_n        = j_r;
    pass_n     = pass_r;
    err_n      = err;
    load_we_s  = 1'b0;
    shift_we_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (load_valid) begin
          if (len_r == DECK_MAX_C) begin
            err_n = 1'b1;
          end else begin
            load_we_s = 1'b1;
            len_n     = len_r + 5'd1;
          end
        end else begin
          load_we_s = 1'b0;
        end
        if (draw_req || take_req) begin
          err_n = 1'b1;
        end else begin
          err_n = err_n;
        end
        if (setup_ready) begin
          state_n = ST_PLAY;
          ptr_n   = 5'd0;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_PLAY: begin
        if (draw_req) begin
          // A take issued alongside a draw loses and is flagged.
          if (take_req) begin
            err_n = 1'b1;
          end else begin
            err_n = err;
          end
          if (talon_s != 5'd0) begin
            ptr_n = ptr_r + step_s;
          end else if (len_r != 5'd0) begin
            ptr_n  = 5'd0;
            pass_n = (pass_r == 4'd15) ? 4'd15 : pass_r + 4'd1;
          end else begin
            ptr_n = ptr_r;
          end
        end else if (take_req) begin
          if (ptr_r == 5'd0) begin
            err_n = 1'b1;
          end else begin
            ptr_n = ptr_r - 5'd1;
            len_n = len_r - 5'd1;
            // Cards above the removed one must slide down one slot each.
            if (talon_s != 5'd0) begin
              state_n = ST_SHIFT;
              j_n     = ptr_r - 5'd1;
            end else begin
              state_n = ST_PLAY;
            end
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      ST_SHIFT: begin
        shift_we_s = 1'b1;
        j_n        = j_r + 5'd1;
        // len_r already holds the shortened length here.
        if (j_r == len_r - 5'd1) begin
          state_n = ST_PLAY;
        end else begin
          state_n = ST_SHIFT;
        end
        if (draw_req || take_req) begin
          err_n = 1'b1;
        end else begin
          err_n = err;
        end
      end
      default: begin
        state_n = ST_LOAD;
      end
    endcase
  end

  // Waste view for the upcoming pointer; the waste region is never rewritten
  // in the same cycle it becomes visible, so the current deck is sufficient.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (ptr_n > 5'(i)) begin
        waste_n[i] = deck[ptr_n - 5'(i) - 5'd1] | VIS_BIT;
      end else begin
        waste_n[i] = '0;
      end
    end
  end

  // Card storage: loads write at the end, shifts close the gap left by a take.
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      deck[len_r] <= load_card & ~VIS_BIT;
    end else if (shift_we_s) begin
      deck[j_r] <= deck[j_r + 5'd1];
    end
  end

  // Controller state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_LOAD;
      ptr_r       <= 5'd0;
      len_r       <= 5'd0;
      j_r         <= 5'd0;
      pass_r      <= 4'd0;
      err         <= 1'b0;
      load_ready  <= 1'b1;
      cmd_ready   <= 1'b0;
      waste0      <= '0;
      waste1      <= '0;
      waste2      <= '0;
      waste_valid <= 3'b000;
      talon_count <= 5'd0;
      waste_count <= 5'd0;
      pass_count  <= 4'd0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      len_r       <= len_n;
      j_r         <= j_n;
      pass_r      <= pass_n;
      err         <= err_n;
      load_ready  <= (state_n == ST_LOAD);
      cmd_ready   <= (state_n == ST_PLAY);
      waste0      <= waste_n[0];
      waste1      <= waste_n[1];
      waste2      <= waste_n[2];
      waste_valid <= {ptr_n > 5'd2, ptr_n > 5'd1, ptr_n > 5'd0};
      talon_count <= len_n - ptr_n;
      waste_count <= ptr_n;
      pass_count  <= pass_n;
    end
  end

endmodule

// File: tb/tb_talon_dealer.sv
// Directed bench for talon_dealer with hand-derived expectations.
module tb_talon_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [6:0] load_card = 7'd0;
  logic       load_ready;
  logic       setup_ready = 1'b0;
  logic       draw_req = 1'b0;
  logic       take_req = 1'b0;
  logic       cmd_ready;
  logic [6:0] waste0, waste1, waste2;
  logic [2:0] waste_valid;
  logic [4:0] talon_count, waste_count;
  logic [3:0] pass_count;
  logic       err;

  int checks = 0;
  int failures = 0;
  logic [6:0] model [24];
  int cnt;

  talon_dealer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_card(load_card),
    .load_ready(load_ready), .setup_ready(setup_ready), .draw_req(draw_req),
    .take_req(take_req), .cmd_ready(cmd_ready), .waste0(waste0), .waste1(waste1),
    .waste2(waste2), .waste_valid(waste_valid), .talon_count(talon_count),
    .waste_count(waste_count), .pass_count(pass_count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(int i);
    logic [3:0] r;
    logic [1:0] s;
    r = 4'(i % 13 + 1);
    s = 2'(i % 4);
    return {r, s, 1'b1};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Loads n cards; setup_ready rides with the last one when requested.
  task automatic load_n(int n, bit setup_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_card  = mk(i);
      if (i < 24) model[i] = mk(i);
      setup_ready = (setup_last && i == n - 1);
      tick();
    end
    load_valid  = 1'b0;
    setup_ready = 1'b0;
  endtask

  task automatic draw();
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_talon", 32'(talon_count), 32'd0);
    check("rst_wvalid", 32'(waste_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Full 24-card load, setup raised with the last card
    load_n(24, 1'b1);
    check("load_talon", 32'(talon_count), 32'd24);
    check("load_waste", 32'(waste_count), 32'd0);
    check("load_wvalid", 32'(waste_valid), 32'd0);
    check("load_err", 32'(err), 32'd0);
    check("load_cmd_ready", 32'(cmd_ready), 32'd1);
    check("load_load_ready", 32'(load_ready), 32'd0);

    // Eight draws empty the talon
    for (int k = 0; k < 8; k++) begin
      draw();
      check($sformatf("draw%0d_waste", k), 32'(waste_count), 32'(3 * (k + 1)));
    end
    check("d8_waste0", 32'(waste0), 32'(model[23]));
    check("d8_waste1", 32'(waste1), 32'(model[22]));
    check("d8_talon", 32'(talon_count), 32'd0);
    check("d8_wvalid", 32'(waste_valid), 32'd7);

    // Recycle, then first draw of the second pass
    draw();
    check("rec_waste", 32'(waste_count), 32'd0);
    check("rec_talon", 32'(talon_count), 32'd24);
    check("rec_pass", 32'(pass_count), 32'd1);
    check("rec_wvalid", 32'(waste_valid), 32'd0);
    draw();
    check("p2_waste0", 32'(waste0), 32'(model[2]));
    check("p2_waste1", 32'(waste1), 32'(model[1]));
    check("p2_waste2", 32'(waste2), 32'(model[0]));

    // Take the top with 21 cards still face down
    take_req = 1'b1;
    tick();
    take_req = 1'b0;
    check("take_talon", 32'(talon_count), 32'd21);
    check("take_waste", 32'(waste_count), 32'd2);
    check("take_waste0", 32'(waste0), 32'(model[1]));
    cnt = 0;
    while (cmd_ready == 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("shift_cycles", 32'(cnt), 32'd21);
    for (int i = 2; i < 23; i++) model[i] = model[i + 1];
    draw();
    check("post_waste2", 32'(waste2), 32'(mk(3)));
    check("post_waste0", 32'(waste0), 32'(model[4]));
    check("post_talon", 32'(talon_count), 32'd18);
    check("post_err", 32'(err), 32'd0);

    // Run out and recycle, then take on an empty waste
    for (int k = 0; k < 6; k++) draw();
    check("run_talon", 32'(talon_count), 32'd0);
    draw();
    check("rec2_pass", 32'(pass_count), 32'd2);
    take_req = 1'b1;
    tick();
    take_req = 1'b0;
    check("empty_take_err", 32'(err), 32'd1);
    check("empty_take_waste", 32'(waste_count), 32'd0);
    check("empty_take_talon", 32'(talon_count), 32'd23);

    // Ten-card deck: last draw turns one card
    do_reset();
    check("rst2_err", 32'(err), 32'd0);
    load_n(10, 1'b1);
    draw(); check("ten_d1", 32'(waste_count), 32'd3);
    draw(); check("ten_d2", 32'(waste_count), 32'd6);
    draw(); check("ten_d3", 32'(waste_count), 32'd9);
    draw(); check("ten_d4", 32'(waste_count), 32'd10);
    check("ten_talon", 32'(talon_count), 32'd0);
    check("ten_waste0", 32'(waste0), 32'(mk(9)));
    check("ten_waste1", 32'(waste1), 32'(mk(8)));
    check("ten_err", 32'(err), 32'd0);

    // 25th card is dropped
    do_reset();
    load_n(25, 1'b1);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_talon", 32'(talon_count), 32'd24);

    // Command during LOAD flags an error
    do_reset();
    draw();
    check("load_cmd_err", 32'(err), 32'd1);
    check("load_cmd_waste", 32'(waste_count), 32'd0);

    // Asynchronous reset in the middle of a shift
    do_reset();
    load_n(24, 1'b1);
    draw();
    take_req = 1'b1;
    tick();
    take_req = 1'b0;
    tick();
    tick();
    check("mid_shift_busy", 32'(cmd_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_load_ready", 32'(load_ready), 32'd1);
    check("ar_cmd_ready", 32'(cmd_ready), 32'd0);
    check("ar_talon", 32'(talon_count), 32'd0);
    check("ar_waste", 32'(waste_count), 32'd0);
    check("ar_wvalid", 32'(waste_valid), 32'd0);
    check("ar_waste0", 32'(waste0), 32'd0);
    check("ar_pass", 32'(pass_count), 32'd0);
    check("ar_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
